// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program-memory port, decode valid/ready handshake and
// the PC redirect input from branch/jump resolution.
interface instr_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pmem_addr;
  logic [DATA_W-1:0] pmem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;

  // fetch stage side
  modport master (
    output pmem_addr,
    input  pmem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_imm,
    output out_pc,
    input  redirect_valid,
    input  redirect_addr
  );

  // memory / decode / branch side
  modport slave (
    input  pmem_addr,
    output pmem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_imm,
    input  out_pc,
    output redirect_valid,
    output redirect_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: walks the PC through a combinational program memory,
// assembles one- or two-word instructions and hands them to decode over
// valid/ready. Redirects win in every state; the halt word parks the stage.
module instr_fetch #(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     bus,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_FETCH_IMM = 2'd1,
    S_HOLD      = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  // opcodes that carry a trailing data word
  localparam logic [3:0] OP_LDI  = 4'b0000;
  localparam logic [3:0] OP_SUBI = 4'b1001;

  state_t            r_state,  w_state_nxt;
  logic [ADDR_W-1:0] r_pc,     w_pc_nxt;
  logic [DATA_W-1:0] r_instr,  w_instr_nxt;
  logic [DATA_W-1:0] r_imm,    w_imm_nxt;
  logic [ADDR_W-1:0] r_opc,    w_opc_nxt;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [3:0]        w_opcode;
  logic              w_two_word;
  logic              w_is_halt;

  // PC wraps naturally at 2^ADDR_W
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_opcode   = bus.pmem_data[DATA_W-1 -: 4];
  assign w_two_word = (w_opcode == OP_LDI) || (w_opcode == OP_SUBI);
  assign w_is_halt  = (bus.pmem_data == HALT_WORD);

  // next-state and next-datapath values; redirect overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_imm_nxt   = r_imm;
    w_opc_nxt   = r_opc;
    if (bus.redirect_valid) begin
      // a bundle in HOLD accepted this same cycle already counts as
      // transferred; anything else in flight is simply dropped
      w_state_nxt = S_FETCH;
      w_pc_nxt    = bus.redirect_addr;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_instr_nxt = bus.pmem_data;
          w_opc_nxt   = r_pc;
          if (w_is_halt) begin
            // PC stays on the halt word
            w_state_nxt = S_HALTED;
          end else if (w_two_word) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH_IMM;
          end else begin
            w_imm_nxt   = '0;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_HOLD;
          end
        end
        S_FETCH_IMM: begin
          w_imm_nxt   = bus.pmem_data;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) w_state_nxt = S_FETCH;
        end
        S_HALTED: begin
          w_state_nxt = S_HALTED;
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  // state, PC and output bundle registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_instr <= '0;
      r_imm   <= '0;
      r_opc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_imm   <= w_imm_nxt;
      r_opc   <= w_opc_nxt;
    end
  end

  // valid only once a bundle is fully assembled
  assign bus.pmem_addr = r_pc;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_instr = r_instr;
  assign bus.out_imm   = r_imm;
  assign bus.out_pc    = r_opc;
  assign halted        = (r_state == S_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table of single instructions, directed
// multi-cycle sequences, then a randomized run against a bundle-level model.
module tb_instr_fetch;
  localparam int          AW   = 5;
  localparam int          DW   = 16;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;
  logic [15:0] mem [32];
  int checks = 0;
  int failures = 0;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .HALT_WORD(HALT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // combinational program memory
  assign bus.pmem_data = mem[bus.pmem_addr];

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [4:0]  e_next;
    int          e_lat;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = HALT;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.out_valid && n < max) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("timeout_valid", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic redirect(input logic [4:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = a;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  function automatic int ilen(input logic [15:0] w);
    return (w[15:12] == 4'h0 || w[15:12] == 4'h9) ? 2 : 1;
  endfunction

  initial begin
    int n;
    logic [4:0] p1, exp_pc, ra;
    logic rd;
    logic [15:0] w;
    int xfers;

    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    clear_mem();

    // ---------------- reset + two-word assembly + backpressure
    mem[0] = 16'h0000; mem[1] = 16'h0006; mem[2] = 16'hA002;
    rst_n = 1'b0;
    tick();
    chk("rst_pmem_addr", bus.pmem_addr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;
    wait_valid(10, n);
    chk("tw_latency", n, 2);
    chk("tw_instr", bus.out_instr, 16'h0000);
    chk("tw_imm", bus.out_imm, 16'h0006);
    chk("tw_pc", bus.out_pc, 0);
    tick();
    bus.out_ready = 1'b0;
    wait_valid(10, n);
    chk("bp_latency", n, 1);
    chk("bp_pc", bus.out_pc, 2);
    chk("bp_instr", bus.out_instr, 16'hA002);
    chk("bp_imm", bus.out_imm, 0);
    chk("bp_addr", bus.pmem_addr, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_instr", bus.out_instr, 16'hA002);
      chk("bp_hold_pc", bus.out_pc, 2);
      chk("bp_hold_addr", bus.pmem_addr, 3);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_once_a", bus.out_valid, 0);
    tick();
    chk("bp_once_b", bus.out_valid, 0);

    // ---------------- redirect during FETCH_IMM
    clear_mem();
    mem[4] = 16'h9000; mem[5] = 16'h0001; mem[10] = 16'h6101; mem[12] = 16'h1234;
    redirect(5'd4);
    chk("rd_addr4", bus.pmem_addr, 4);
    tick();
    chk("rd_in_imm_valid", bus.out_valid, 0);
    chk("rd_in_imm_addr", bus.pmem_addr, 5);
    redirect(5'd10);
    chk("rd_valid_drop", bus.out_valid, 0);
    chk("rd_addr10", bus.pmem_addr, 10);
    tick();
    chk("rd_bundle_valid", bus.out_valid, 1);
    chk("rd_bundle_pc", bus.out_pc, 10);
    chk("rd_bundle_instr", bus.out_instr, 16'h6101);
    chk("rd_bundle_imm", bus.out_imm, 0);

    // ---------------- redirect coinciding with a handshake
    redirect(5'd12);
    wait_valid(10, n);
    chk("hsrd_pc12", bus.out_pc, 12);
    bus.out_ready = 1'b1;
    redirect(5'd10);
    bus.out_ready = 1'b0;
    chk("hsrd_valid_drop", bus.out_valid, 0);
    chk("hsrd_addr", bus.pmem_addr, 10);
    wait_valid(10, n);
    chk("hsrd_latency", n, 1);
    chk("hsrd_pc10", bus.out_pc, 10);

    // ---------------- halt
    clear_mem();
    mem[13] = 16'h2345; mem[14] = HALT;
    bus.out_ready = 1'b1;
    redirect(5'd13);
    wait_valid(10, n);
    chk("h_pc13", bus.out_pc, 13);
    tick();
    chk("h_pre_halted", halted, 0);
    chk("h_addr14", bus.pmem_addr, 14);
    tick();
    chk("h_halted_rise", halted, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("h_stay_valid", bus.out_valid, 0);
      chk("h_stay_halted", halted, 1);
      chk("h_stay_addr", bus.pmem_addr, 14);
    end
    mem[0] = 16'h0000; mem[1] = 16'h0006;
    bus.out_ready = 1'b0;
    redirect(5'd0);
    chk("h_release", halted, 0);
    wait_valid(10, n);
    chk("h_restart_instr", bus.out_instr, 16'h0000);
    chk("h_restart_imm", bus.out_imm, 16'h0006);

    // ---------------- wrap
    clear_mem();
    mem[31] = 16'h9000; mem[0] = 16'h0004;
    redirect(5'd31);
    wait_valid(10, n);
    chk("wr_latency", n, 2);
    chk("wr_pc", bus.out_pc, 31);
    chk("wr_instr", bus.out_instr, 16'h9000);
    chk("wr_imm", bus.out_imm, 16'h0004);
    chk("wr_next_addr", bus.pmem_addr, 1);

    // ---------------- reset mid-operation (in HOLD, valid high)
    chk("rm_pre_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_valid", bus.out_valid, 0);
    chk("rm_addr", bus.pmem_addr, 0);
    chk("rm_instr", bus.out_instr, 0);
    chk("rm_imm", bus.out_imm, 0);
    chk("rm_pc", bus.out_pc, 0);
    chk("rm_halted", halted, 0);

    // ---------------- vector table: single instructions
    vt[0] = '{5'd3,  16'h0ABC, 16'h1357, 16'h0ABC, 16'h1357, 5'd5,  2};
    vt[1] = '{5'd7,  16'h9123, 16'hBEEF, 16'h9123, 16'hBEEF, 5'd9,  2};
    vt[2] = '{5'd8,  16'h8123, 16'h5555, 16'h8123, 16'h0000, 5'd9,  1};
    vt[3] = '{5'd20, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 5'd21, 1};
    vt[4] = '{5'd30, 16'hF000, 16'h0000, 16'hF000, 16'h0000, 5'd31, 1};
    vt[5] = '{5'd31, 16'h0001, 16'h4242, 16'h0001, 16'h4242, 5'd1,  2};
    vt[6] = '{5'd31, 16'h7777, 16'h0000, 16'h7777, 16'h0000, 5'd0,  1};
    vt[7] = '{5'd16, 16'hFFFE, 16'h0000, 16'hFFFE, 16'h0000, 5'd17, 1};
    for (int v = 0; v < 8; v++) begin
      clear_mem();
      p1 = vt[v].pc + 5'd1;
      mem[vt[v].pc] = vt[v].w0;
      mem[p1] = vt[v].w1;
      bus.out_ready = 1'b0;
      redirect(vt[v].pc);
      chk("vt_addr", bus.pmem_addr, vt[v].pc);
      wait_valid(10, n);
      chk("vt_latency", n, vt[v].e_lat);
      chk("vt_instr", bus.out_instr, vt[v].e_instr);
      chk("vt_imm", bus.out_imm, vt[v].e_imm);
      chk("vt_pc", bus.out_pc, vt[v].pc);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("vt_next_addr", bus.pmem_addr, vt[v].e_next);
    end

    // ---------------- randomized run vs bundle-level model
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 19) == 0) w = HALT;
      else if ($urandom_range(0, 2) == 0) w[15:12] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'h9;
      mem[i] = w;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_pc = 5'd0;
    xfers = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 15) == 0);
      ra = 5'($urandom_range(0, 31));
      bus.redirect_valid = rd;
      bus.redirect_addr = ra;
      if (bus.out_valid && bus.out_ready) begin
        p1 = exp_pc + 5'd1;
        chk("rnd_pc", bus.out_pc, exp_pc);
        chk("rnd_instr", bus.out_instr, mem[exp_pc]);
        chk("rnd_imm", bus.out_imm, (ilen(mem[exp_pc]) == 2) ? mem[p1] : 16'h0000);
        exp_pc = exp_pc + 5'(ilen(mem[exp_pc]));
        xfers++;
      end
      if (halted) begin
        chk("rnd_halt_word", mem[bus.pmem_addr], HALT);
        chk("rnd_halt_pc", bus.pmem_addr, exp_pc);
      end
      if (rd) exp_pc = ra;
      tick();
      if (rd) chk("rnd_redir_addr", bus.pmem_addr, ra);
    end
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("rnd_progress", (xfers > 100) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of `program_memory`. It drives the program memory's 5-bit address and consumes its 16-bit combinational `instr_out`. It assembles one- or two-word instructions (opcode plus trailing data word) and presents them to the decode stage over a valid/ready handshake. It also accepts PC redirects from the branch/jump logic and halts on the end-of-program word.

## Interface
- `ADDR_W`, 5: program counter / memory address width.
- `DATA_W`, 16: instruction word width.
- `HALT_WORD`, 16'hFFFF: word that stops fetching; this is the program memory's default for unused addresses.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pmem_addr` out ADDR_W: address to program memory; combinationally equal to the PC register.
- `pmem_data` in DATA_W: program memory `instr_out`, valid in the same cycle as `pmem_addr`.
- `out_valid` out 1: instruction bundle available to decode.
- `out_ready` in 1: decode accepts the bundle when `out_valid & out_ready`.
- `out_instr` out DATA_W: first (opcode) word.
- `out_imm` out DATA_W: trailing data word for two-word instructions; 0 otherwise.
- `out_pc` out ADDR_W: address of the first word.
- `redirect_valid` in 1: load the PC from `redirect_addr` (JMP/BRNE taken).
- `redirect_addr` in ADDR_W: redirect target.
- `halted` out 1: high while in HALTED.

## Operation
- Two-word opcodes, taken from `pmem_data[15:12]`: 4'b0000 (load immediate) and 4'b1001 (SUBi). All other opcodes are one-word, including ADDI, whose immediate is inline.
- States:
  - FETCH: latch `pmem_data` into `out_instr` and PC into `out_pc`.
    - If `pmem_data == HALT_WORD`, go to HALTED and do not advance the PC.
    - Else if the opcode is two-word, PC+1 and go to FETCH_IMM.
    - Else clear `out_imm`, PC+1, and go to HOLD.
  - FETCH_IMM: latch `pmem_data` into `out_imm`, PC+1, go to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, go to FETCH. Output registers stay stable while waiting.
  - HALTED: `out_valid`=0, `halted`=1. Remain here until a redirect or reset.
- PC arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0. A two-word instruction at address 31 takes its data word from address 0.
- Redirect has priority in every state, including HALTED:
  - Next state is FETCH and PC = `redirect_addr`.
  - Any partially assembled or unaccepted bundle is discarded; `out_valid` drops the next cycle.
  - If `out_valid & out_ready & redirect_valid` occur in the same cycle, the bundle counts as transferred and the redirect still applies.
- `out_valid` is never asserted for a half-assembled two-word instruction.

## Timing
- Reset (`rst_n`=0 at a clock edge): PC=0, state FETCH.
  - Outputs: `pmem_addr`=0, `out_valid`=0, `out_instr`=0, `out_imm`=0, `out_pc`=0, `halted`=0.
  - Reset mid-operation discards everything.
- Latency:
  - One-word instruction: FETCH at edge n, `out_valid` high after edge n+1.
  - Two-word instruction: `out_valid` high one cycle later.
- Throughput with `out_ready` held at 1:
  - one-word: one instruction every 2 cycles;
  - two-word: one instruction every 3 cycles.
- Redirect: PC and `pmem_addr` equal `redirect_addr` the cycle after `redirect_valid`. The first redirected bundle becomes valid 2 cycles after the redirect (one-word case).
- `halted` rises one cycle after the edge on which FETCH sees HALT_WORD.

## Test plan
- **Two-word assembly:** memory[0]=0x0000, [1]=0x0006, `out_ready`=1 from reset.
  - First handshake: `out_instr`=0x0000, `out_imm`=0x0006, `out_pc`=0.
  - Next bundle: `out_pc`=2, `out_instr`=0xA002, `out_imm`=0.
- **Backpressure:** [2]=0xA002, hold `out_ready`=0 for 5 cycles.
  - `out_valid` stays 1 and outputs stay stable.
  - `pmem_addr` stays 3.
  - Releasing `out_ready` transfers exactly once.
- **Redirect:** assert `redirect_valid` with addr 10 while in FETCH_IMM for the SUBi at 4.
  - The SUBi bundle is never presented.
  - Next bundle: `out_pc`=10, `out_instr`=0x6101.
  - Also cover redirect coinciding with a handshake: one transfer, then target 10.
- **Halt:** run the program through address 13, with [14]=0xFFFF.
  - After the bundle at 13, `halted`=1 and `out_valid` stays 0 for 20 cycles.
  - `redirect_valid` to 0 restarts with `out_instr`=0x0000.
- **Wrap:** [31]=0x9000, [0]=0x0004, redirect to 31.
  - Bundle: `out_pc`=31, `out_imm`=0x0004.
  - Next fetch from address 1.
- **Reset mid-op:** drop `rst_n` during HOLD with `out_valid`=1.
  - Next cycle: all outputs are at reset values and `pmem_addr`=0.
